// File: rtl/m_ext_unit.sv
// m_ext_unit: iterative RV32 M-extension multiply/divide/remainder unit, one bit per cycle.
// Optional macro M_EXT_EARLY_OUT_EN short-circuits zero operands, divide-by-zero and signed overflow.
module m_ext_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mulop,
  input  logic        rs1_signed,
  input  logic        rs2_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_DIV = 2'd1;
  localparam logic [1:0] OP_REM = 2'd2;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  // control state
  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic [31:0] res_hi_q, res_hi_d;

  // latched operation and iteration datapath
  logic [1:0]  op_q, op_d;
  logic        sgn_a_q, sgn_a_d;
  logic        sgn_b_q, sgn_b_d;
  logic [31:0] a_q, a_d;
  logic        b_zero_q, b_zero_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        early_q, early_d;
  logic [31:0] early_lo_q, early_lo_d;
  logic [31:0] early_hi_q, early_hi_d;

  logic        accept;
  logic        in_div;
  logic        in_sgn_a, in_sgn_b;
  logic [31:0] in_mag_a, in_mag_b;
  logic        early_hit;
  logic [31:0] early_lo, early_hi;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_tmp;
  logic [33:0] div_diff;
  logic        div_ge;
  logic [63:0] div_next;

  logic [63:0] prod;
  logic [31:0] quot, rem;
  logic [31:0] fix_lo, fix_hi;

  // A new request may land in the DONE cycle so back-to-back ops lose no cycle.
  assign accept = start & ~flush & ((state_q == S_IDLE) | (state_q == S_DONE));

  always_comb begin
    in_div   = (mulop == OP_DIV) || (mulop == OP_REM);
    in_sgn_a = 1'b0;
    in_sgn_b = 1'b0;
    if (mulop == OP_MUL) begin
      in_sgn_a = rs1_signed & a[31];
      in_sgn_b = rs2_signed & b[31];
    end else if (in_div) begin
      in_sgn_a = rs1_signed & rs2_signed & a[31];
      in_sgn_b = rs1_signed & rs2_signed & b[31];
    end
    in_mag_a = in_sgn_a ? neg32(a) : a;
    in_mag_b = in_sgn_b ? neg32(b) : b;
  end

`ifdef M_EXT_EARLY_OUT_EN
  logic        in_ovf;
  logic [31:0] early_quot, early_rem;

  always_comb begin
    in_ovf     = in_div & rs1_signed & rs2_signed &
                 (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
    early_hit  = (mulop != 2'd3) & ((a == 32'd0) | (b == 32'd0) | in_ovf);
    early_quot = 32'd0;
    early_rem  = 32'd0;
    if (b == 32'd0) begin
      early_quot = 32'hFFFF_FFFF;
      early_rem  = a;
    end else if (in_ovf) begin
      early_quot = 32'h8000_0000;
    end
    early_lo = (mulop == OP_REM) ? early_rem  : early_quot;
    early_hi = (mulop == OP_REM) ? early_quot : early_rem;
    if (mulop == OP_MUL) begin
      early_lo = 32'd0;
      early_hi = 32'd0;
    end
  end
`else
  always_comb begin
    early_hit = 1'b0;
    early_lo  = 32'd0;
    early_hi  = 32'd0;
  end
`endif

  // Shift-add multiply: multiplier sits in acc[31:0] and is consumed from the bottom.
  // Restoring divide: remainder in acc[63:32], quotient bits shift into acc[31:0].
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q & {32{acc_q[0]}}};
    mul_next = {mul_sum, acc_q[31:1]};
    div_tmp  = {acc_q[63:32], acc_q[31]};
    div_diff = {1'b0, div_tmp} - {2'b00, opnd_q};
    // Bit 32 of a non-negative difference is always clear, so folding it in changes nothing.
    div_ge   = ~(div_diff[33] | div_diff[32]);
    div_next = div_ge ? {div_diff[31:0], acc_q[30:0], 1'b1}
                      : {div_tmp[31:0],  acc_q[30:0], 1'b0};
  end

  always_comb begin
    op_d       = op_q;
    sgn_a_d    = sgn_a_q;
    sgn_b_d    = sgn_b_q;
    a_d        = a_q;
    b_zero_d   = b_zero_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    early_d    = early_q;
    early_lo_d = early_lo_q;
    early_hi_d = early_hi_q;
    if (accept) begin
      op_d       = mulop;
      sgn_a_d    = in_sgn_a;
      sgn_b_d    = in_sgn_b;
      a_d        = a;
      b_zero_d   = (b == 32'd0);
      early_d    = early_hit;
      early_lo_d = early_lo;
      early_hi_d = early_hi;
      if (mulop == OP_MUL) begin
        acc_d  = {32'd0, in_mag_b};
        opnd_d = in_mag_a;
      end else begin
        acc_d  = {32'd0, in_mag_a};
        opnd_d = in_mag_b;
      end
    end else if (state_q == S_CALC) begin
      acc_d = (op_q == OP_MUL) ? mul_next : div_next;
    end
  end

  // Sign correction on magnitudes; divide-by-zero must bypass it to return all-ones / dividend.
  always_comb begin
    prod = (sgn_a_q ^ sgn_b_q) ? neg64(acc_q) : acc_q;
    quot = (sgn_a_q ^ sgn_b_q) ? neg32(acc_q[31:0]) : acc_q[31:0];
    rem  = sgn_a_q ? neg32(acc_q[63:32]) : acc_q[63:32];
    if (b_zero_q) begin
      quot = 32'hFFFF_FFFF;
      rem  = a_q;
    end
    fix_lo = 32'd0;
    fix_hi = 32'd0;
    if (early_q) begin
      fix_lo = early_lo_q;
      fix_hi = early_hi_q;
    end else begin
      case (op_q)
        OP_MUL: begin
          fix_lo = prod[31:0];
          fix_hi = prod[63:32];
        end
        OP_DIV: begin
          fix_lo = quot;
          fix_hi = rem;
        end
        OP_REM: begin
          fix_lo = rem;
          fix_hi = quot;
        end
        default: begin
          fix_lo = 32'd0;
          fix_hi = 32'd0;
        end
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = early_hit ? S_FIX : S_CALC;
          cnt_d   = 5'd0;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_DONE;
          res_lo_d = fix_lo;
          res_hi_d = fix_hi;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      res_lo_q <= 32'd0;
      res_hi_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q       <= op_d;
    sgn_a_q    <= sgn_a_d;
    sgn_b_q    <= sgn_b_d;
    a_q        <= a_d;
    b_zero_q   <= b_zero_d;
    acc_q      <= acc_d;
    opnd_q     <= opnd_d;
    early_q    <= early_d;
    early_lo_q <= early_lo_d;
    early_hi_q <= early_hi_d;
  end

  assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign done      = (state_q == S_DONE);
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;

endmodule

// File: tb/tb_m_ext_unit.sv
// Directed testbench for m_ext_unit: mul/div/rem vectors, special cases, flush, reset, back-to-back.
module tb_m_ext_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mulop = 2'd0;
  logic        rs1_signed = 1'b0;
  logic        rs2_signed = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int LAT = 34;
`ifdef M_EXT_EARLY_OUT_EN
  localparam int LAT_SPECIAL = 2;
`else
  localparam int LAT_SPECIAL = 34;
`endif

  always #5 clk = ~clk;

  m_ext_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mulop      (mulop),
    .rs1_signed (rs1_signed),
    .rs2_signed (rs2_signed),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .result_lo  (result_lo),
    .result_hi  (result_hi)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Starts an op in the current cycle, scrambles inputs afterwards, and checks the result at done.
  task automatic run_op(input string name, input logic [1:0] op, input logic s1, input logic s2,
                        input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input int exp_lat, input bit hold_chk);
    int k;
    bit seen;
    start = 1'b1; mulop = op; rs1_signed = s1; rs2_signed = s2; a = va; b = vb;
    next_cycle();
    k = 1;
    start = 1'b0; a = ~va; b = vb ^ 32'h5A5A_0F0F; mulop = op ^ 2'b01;
    rs1_signed = ~s1; rs2_signed = ~s2;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    end
    seen = 1'b0;
    while (k < 100) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      next_cycle();
      k++;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: done not seen within %0d cycles", name, k);
    end else begin
      n_checks++;
      if (k !== exp_lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want %0d", name, k, exp_lat);
      end
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy_at_done: got %b want 0", name, busy);
      end
      n_checks++;
      if (result_lo !== exp_lo) begin
        n_fail++;
        $display("FAIL %s result_lo: got %h want %h", name, result_lo, exp_lo);
      end
      n_checks++;
      if (result_hi !== exp_hi) begin
        n_fail++;
        $display("FAIL %s result_hi: got %h want %h", name, result_hi, exp_hi);
      end
      if (hold_chk) begin
        next_cycle();
        n_checks++;
        if (done !== 1'b0) begin
          n_fail++;
          $display("FAIL %s done_pulse_width: got %b want 0", name, done);
        end
        n_checks++;
        if (result_lo !== exp_lo || result_hi !== exp_hi) begin
          n_fail++;
          $display("FAIL %s result_hold: got %h_%h want %h_%h", name, result_hi, result_lo,
                   exp_hi, exp_lo);
        end
      end
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    repeat (2) next_cycle();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy=%b done=%b want 0 0", busy, done);
    end
    n_checks++;
    if (result_lo !== 32'd0 || result_hi !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_results: got %h_%h want 0_0", result_hi, result_lo);
    end
    start = 1'b0;
    rst_n = 1'b1;
    next_cycle();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_accept: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_mul();
    run_op("mul_neg1x2",  2'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002,
           32'hFFFF_FFFE, 32'hFFFF_FFFF, LAT, 1'b1);
    run_op("mulhu_max",   2'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h0000_0001, 32'hFFFF_FFFE, LAT, 1'b0);
    run_op("mulhsu_max",  2'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h0000_0001, 32'hFFFF_FFFF, LAT, 1'b0);
    run_op("mul_neg7x6",  2'd0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0006,
           32'hFFFF_FFD6, 32'hFFFF_FFFF, LAT, 1'b0);
    run_op("mul_2p32",    2'd0, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000,
           32'h0000_0000, 32'h0000_0001, LAT, 1'b0);
  endtask

  task automatic test_div();
    run_op("div_neg7_2",  2'd1, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002,
           32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT, 1'b0);
    run_op("rem_neg7_2",  2'd2, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT, 1'b0);
    run_op("divu_100_7",  2'd1, 1'b0, 1'b0, 32'd100, 32'd7,
           32'd14, 32'd2, LAT, 1'b0);
    run_op("div_mixed",   2'd1, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002,
           32'h7FFF_FFFC, 32'h0000_0001, LAT, 1'b0);
    run_op("remu_mixed",  2'd2, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002,
           32'h0000_0001, 32'h7FFF_FFFC, LAT, 1'b0);
  endtask

  task automatic test_special();
    run_op("div_by_zero", 2'd1, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_0000,
           32'hFFFF_FFFF, 32'h0000_1234, LAT_SPECIAL, 1'b1);
    run_op("rem_by_zero", 2'd2, 1'b0, 1'b0, 32'h0000_0055, 32'h0000_0000,
           32'h0000_0055, 32'hFFFF_FFFF, LAT_SPECIAL, 1'b0);
    run_op("divs_by_zero", 2'd1, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0000,
           32'hFFFF_FFFF, 32'hFFFF_FFF9, LAT_SPECIAL, 1'b0);
    run_op("div_ovf",     2'd1, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 32'h0000_0000, LAT_SPECIAL, 1'b0);
    run_op("rem_ovf",     2'd2, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0000_0000, 32'h8000_0000, LAT_SPECIAL, 1'b0);
    run_op("mul_zero",    2'd0, 1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF,
           32'h0000_0000, 32'h0000_0000, LAT_SPECIAL, 1'b0);
    run_op("op_reserved", 2'd3, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0003,
           32'h0000_0000, 32'h0000_0000, LAT, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first",   2'd0, 1'b0, 1'b0, 32'd3, 32'd5,
           32'd15, 32'd0, LAT, 1'b0);
    run_op("b2b_second",  2'd1, 1'b0, 1'b0, 32'd100, 32'd7,
           32'd14, 32'd2, LAT, 1'b1);
  endtask

  task automatic test_flush();
    int k;
    int nd;
    run_op("flush_pre",   2'd0, 1'b0, 1'b0, 32'd3, 32'd5,
           32'd15, 32'd0, LAT, 1'b1);
    start = 1'b1; mulop = 2'd1; rs1_signed = 1'b0; rs2_signed = 1'b0; a = 32'd100; b = 32'd7;
    next_cycle();
    k = 1;
    nd = 0;
    start = 1'b0;
    while (k < 10) begin
      if (done === 1'b1) nd++;
      next_cycle();
      k++;
    end
    flush = 1'b1;
    start = 1'b1;
    next_cycle();
    flush = 1'b0;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_busy: got %b want 0", busy);
    end
    n_checks++;
    if (done !== 1'b0 || nd !== 0) begin
      n_fail++;
      $display("FAIL flush_no_done: got done=%b earlier=%0d want 0 0", done, nd);
    end
    n_checks++;
    if (result_lo !== 32'd15 || result_hi !== 32'd0) begin
      n_fail++;
      $display("FAIL flush_results_kept: got %h_%h want 0_f", result_hi, result_lo);
    end
    run_op("after_flush", 2'd0, 1'b0, 1'b0, 32'd7, 32'd6,
           32'd42, 32'd0, LAT, 1'b1);
    start = 1'b1; flush = 1'b1;
    next_cycle();
    start = 1'b0; flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_with_start_idle: got busy=%b want 0", busy);
    end
    next_cycle();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_with_start_later: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_held_start();
    int k;
    int ndone;
    int first_at;
    logic [31:0] cap_lo, cap_hi;
    start = 1'b1; mulop = 2'd0; rs1_signed = 1'b1; rs2_signed = 1'b1;
    a = 32'hFFFF_FFF9; b = 32'h0000_0006;
    next_cycle();
    k = 1;
    start = 1'b0;
    ndone = 0;
    first_at = 0;
    cap_lo = 32'd0;
    cap_hi = 32'd0;
    while (k <= 40) begin
      if (done === 1'b1) begin
        ndone++;
        if (first_at == 0) begin
          first_at = k;
          cap_lo = result_lo;
          cap_hi = result_hi;
        end
      end
      start = (k >= 5 && k <= 7);
      a = 32'h0000_0011;
      b = 32'h0000_0022;
      next_cycle();
      k++;
    end
    start = 1'b0;
    n_checks++;
    if (ndone !== 1 || first_at !== LAT) begin
      n_fail++;
      $display("FAIL held_start_done: got count=%0d at=%0d want 1 at %0d", ndone, first_at, LAT);
    end
    n_checks++;
    if (cap_lo !== 32'hFFFF_FFD6 || cap_hi !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL held_start_result: got %h_%h want ffffffff_ffffffd6", cap_hi, cap_lo);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    start = 1'b1; mulop = 2'd0; rs1_signed = 1'b0; rs2_signed = 1'b0; a = 32'd3; b = 32'd5;
    next_cycle();
    k = 1;
    start = 1'b0;
    while (k < 20) begin
      next_cycle();
      k++;
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_busy_before: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_ctrl: got busy=%b done=%b want 0 0", busy, done);
    end
    n_checks++;
    if (result_lo !== 32'd0 || result_hi !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_results: got %h_%h want 0_0", result_hi, result_lo);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_after: got busy=%b done=%b want 0 0", busy, done);
    end
    run_op("after_reset", 2'd0, 1'b0, 1'b0, 32'd3, 32'd5,
           32'd15, 32'd0, LAT, 1'b1);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_flush();
    test_held_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
